// File: rtl/chroma_key_pkg.sv
// Shared types, default widths and helpers for the chroma-key compositor.
package chroma_key_pkg;

  localparam int DW = 12;
  localparam int CNT_W = 24;
  localparam logic [DW-1:0] THRESH_RST = 12'd256;

  typedef struct packed {
    logic [DW-1:0] r;
    logic [DW-1:0] g;
    logic [DW-1:0] b;
  } rgb_t;

  function automatic logic [DW-1:0] max_dw(input logic [DW-1:0] a, input logic [DW-1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/chroma_key_cmp.sv
// Combinational key classifier: green must exceed max(R,B) plus the threshold.
// The sum is formed one bit wider so the largest threshold cannot wrap.
module chroma_key_cmp #(
  parameter int DW = 12
) (
  input  logic [DW-1:0] g,
  input  logic [DW-1:0] mx,
  input  logic [DW-1:0] thr,
  input  logic          bypass,
  output logic          key
);

  logic [DW:0] limit;

  assign limit = {1'b0, mx} + {1'b0, thr};
  assign key   = ~bypass & ({1'b0, g} > limit);

endmodule

// File: rtl/chroma_key_mixer.sv
// Green-screen compositor behind the demosaic stage: 3-clock pipeline that swaps
// key pixels for the lock-step background and counts key pixels per frame.
// Optional build macro CHROMA_KEY_SPILL_EN clamps foreground green to max(R,B).
module chroma_key_mixer #(
  parameter int DW = 12,
  parameter int CNT_W = 24,
  parameter logic [DW-1:0] THRESH_RST = 12'd256
) (
  input  logic             iCLK,
  input  logic             iRST_n,
  input  logic [DW-1:0]    iRed,
  input  logic [DW-1:0]    iGreen,
  input  logic [DW-1:0]    iBlue,
  input  logic             iDval,
  input  logic [DW-1:0]    iBg_Red,
  input  logic [DW-1:0]    iBg_Green,
  input  logic [DW-1:0]    iBg_Blue,
  input  logic             iSOF,
  input  logic [DW-1:0]    iThresh,
  input  logic             iBypass,
  output logic [DW-1:0]    oRed,
  output logic [DW-1:0]    oGreen,
  output logic [DW-1:0]    oBlue,
  output logic             oDval,
  output logic             oKey,
  output logic [CNT_W-1:0] oKey_Count
);

  import chroma_key_pkg::*;

  rgb_t            camIn, bgIn;
  rgb_t            s1Cam, s1Bg, s2Cam, s2Bg;
  logic [DW-1:0]   s1Mx, s2Mx;
  logic            s1Val, s2Val, s2Key;
  logic            cmpKey;
  logic [DW-1:0]   thrAct;
  logic            bypassAct;
  logic [DW-1:0]   fgGreen;
  logic [CNT_W-1:0] acc, accInc;

  assign camIn = '{r: iRed, g: iGreen, b: iBlue};
  assign bgIn  = '{r: iBg_Red, g: iBg_Green, b: iBg_Blue};

  chroma_key_cmp #(.DW(DW)) uCmp (
    .g      (s1Cam.g),
    .mx     (s1Mx),
    .thr    (thrAct),
    .bypass (bypassAct),
    .key    (cmpKey)
  );

`ifdef CHROMA_KEY_SPILL_EN
  assign fgGreen = (!bypassAct && (s2Cam.g > s2Mx)) ? s2Mx : s2Cam.g;
`else
  assign fgGreen = s2Cam.g;
`endif

  // Saturating increment for the key pixel currently presented at the output.
  assign accInc = (oDval && oKey && (acc != {CNT_W{1'b1}})) ? acc + 1'b1 : acc;

  // Shadow controls: new threshold/bypass take effect only at frame start.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      thrAct    <= THRESH_RST;
      bypassAct <= 1'b0;
    end else if (iSOF) begin
      thrAct    <= iThresh;
      bypassAct <= iBypass;
    end
  end

  // S1 and S2: register pixels, then classify; invalid slots never key.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      s1Cam <= '0;
      s1Bg  <= '0;
      s1Mx  <= '0;
      s1Val <= 1'b0;
      s2Cam <= '0;
      s2Bg  <= '0;
      s2Mx  <= '0;
      s2Val <= 1'b0;
      s2Key <= 1'b0;
    end else begin
      s1Cam <= camIn;
      s1Bg  <= bgIn;
      s1Mx  <= max_dw(iRed, iBlue);
      s1Val <= iDval;
      s2Cam <= s1Cam;
      s2Bg  <= s1Bg;
      s2Mx  <= s1Mx;
      s2Val <= s1Val;
      s2Key <= cmpKey & s1Val;
    end
  end

  // S3: select background for key pixels, camera (optionally despilled) otherwise.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      oRed   <= '0;
      oGreen <= '0;
      oBlue  <= '0;
      oDval  <= 1'b0;
      oKey   <= 1'b0;
    end else begin
      oDval <= s2Val;
      oKey  <= s2Key;
      if (s2Key) begin
        oRed   <= s2Bg.r;
        oGreen <= s2Bg.g;
        oBlue  <= s2Bg.b;
      end else begin
        oRed   <= s2Cam.r;
        oGreen <= fgGreen;
        oBlue  <= s2Cam.b;
      end
    end
  end

  // Per-frame key counter; frame start publishes the total including this cycle's pixel.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      acc        <= '0;
      oKey_Count <= '0;
    end else if (iSOF) begin
      oKey_Count <= accInc;
      acc        <= '0;
    end else begin
      acc <= accInc;
    end
  end

endmodule

// File: tb/tb_chroma_key_mixer.sv
// Randomized bench for chroma_key_mixer against a per-pixel behavioural model.
module tb_chroma_key_mixer;

  logic        iCLK = 1'b0;
  logic        iRST_n = 1'b0;
  logic [11:0] iRed = '0, iGreen = '0, iBlue = '0;
  logic        iDval = 1'b0;
  logic [11:0] iBg_Red = '0, iBg_Green = '0, iBg_Blue = '0;
  logic        iSOF = 1'b0;
  logic [11:0] iThresh = '0;
  logic        iBypass = 1'b0;
  logic [11:0] oRed, oGreen, oBlue;
  logic        oDval, oKey;
  logic [23:0] oKey_Count;

  chroma_key_mixer dut (
    .iCLK(iCLK), .iRST_n(iRST_n),
    .iRed(iRed), .iGreen(iGreen), .iBlue(iBlue), .iDval(iDval),
    .iBg_Red(iBg_Red), .iBg_Green(iBg_Green), .iBg_Blue(iBg_Blue),
    .iSOF(iSOF), .iThresh(iThresh), .iBypass(iBypass),
    .oRed(oRed), .oGreen(oGreen), .oBlue(oBlue),
    .oDval(oDval), .oKey(oKey), .oKey_Count(oKey_Count)
  );

  always #5 iCLK = ~iCLK;

  typedef struct {
    bit v;
    bit k;
    int r;
    int g;
    int b;
  } exp_t;

  exp_t expQ[$];
  int   nChecks = 0;
  int   nErrors = 0;
  int   thrM, bypM, expAcc, expCount;
  int   curThr = 0;
  int   curByp = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nErrors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic modelReset();
    exp_t idle;
    idle = '{v: 0, k: 0, r: 0, g: 0, b: 0};
    expQ.delete();
    expQ.push_back(idle);
    expQ.push_back(idle);
    thrM = 256;
    bypM = 0;
    expAcc = 0;
    expCount = 0;
  endtask

  // One clock: apply inputs, predict the output 3 clocks later, compare what is due now.
  task automatic drive(input bit v, input int r, input int g, input int b,
                       input int br, input int bgg, input int bb, input bit sof);
    exp_t e, got;
    int mx, gOut;
    iDval = v; iRed = r[11:0]; iGreen = g[11:0]; iBlue = b[11:0];
    iBg_Red = br[11:0]; iBg_Green = bgg[11:0]; iBg_Blue = bb[11:0];
    iSOF = sof; iThresh = curThr[11:0]; iBypass = curByp[0];
    mx = (r > b) ? r : b;
    e.v = v;
    e.k = v && (bypM == 0) && (g > mx + thrM);
    gOut = g;
`ifdef CHROMA_KEY_SPILL_EN
    if (bypM == 0 && g > mx) gOut = mx;
`endif
    if (e.k) begin e.r = br; e.g = bgg; e.b = bb; end
    else begin e.r = r; e.g = gOut; e.b = b; end
    expQ.push_back(e);
    @(posedge iCLK);
    #1;
    if (sof) begin
      expCount = expAcc;
      expAcc = 0;
      thrM = curThr;
      bypM = curByp;
    end
    got = expQ.pop_front();
    check("dval", {31'b0, oDval}, {31'b0, got.v});
    check("key", {31'b0, oKey}, {31'b0, got.k});
    if (got.v) begin
      check("red", {20'b0, oRed}, got.r);
      check("green", {20'b0, oGreen}, got.g);
      check("blue", {20'b0, oBlue}, got.b);
    end
    check("count", {8'b0, oKey_Count}, expCount);
    if (got.v && got.k) expAcc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      drive(0, $urandom_range(0, 4095), $urandom_range(0, 4095), $urandom_range(0, 4095), 0, 0, 0, 0);
  endtask

  task automatic frameStart(input int thr, input int byp);
    curThr = thr;
    curByp = byp;
    drive(0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic randPixel();
    drive(1, $urandom_range(0, 2000), $urandom_range(0, 4095), $urandom_range(0, 2000),
          $urandom_range(0, 4095), $urandom_range(0, 4095), $urandom_range(0, 4095), 0);
  endtask

  task automatic applyReset();
    #2 iRST_n = 1'b0;
    iDval = 1'b0;
    iSOF = 1'b0;
    #1;
    check("rst_dval", {31'b0, oDval}, 0);
    check("rst_key", {31'b0, oKey}, 0);
    check("rst_count", {8'b0, oKey_Count}, 0);
    @(negedge iCLK);
    @(negedge iCLK);
    iRST_n = 1'b1;
    curThr = 0;
    curByp = 0;
    modelReset();
  endtask

  initial begin
    int keysLeft, r, b, mx;
    modelReset();
    @(negedge iCLK);
    @(negedge iCLK);
    check("reset_dval", {31'b0, oDval}, 0);
    check("reset_count", {8'b0, oKey_Count}, 0);
    iRST_n = 1'b1;

    // Reset threshold 256 applies before any frame start.
    drive(1, 100, 500, 80, 1, 2, 3, 0);
    idle(3);
    frameStart(400, 0);
    drive(1, 100, 500, 80, 1, 2, 3, 0);
    idle(3);

    // Boundaries of the threshold comparison.
    frameStart(0, 0);
    drive(1, 4095, 4095, 4095, 7, 7, 7, 0);
    drive(1, 0, 1, 0, 9, 9, 9, 0);
    drive(1, 10, 11, 10, 5, 5, 5, 0);
    drive(1, 10, 10, 10, 5, 5, 5, 0);
    idle(3);
    frameStart(4095, 0);
    drive(1, 0, 4095, 0, 4, 4, 4, 0);
    idle(3);
    frameStart(100, 0);
    drive(1, 50, 150, 20, 6, 6, 6, 0);
    drive(1, 50, 151, 20, 6, 6, 6, 0);
    idle(3);

    // 1000-pixel frame with exactly 300 keys, then an all-foreground frame.
    frameStart(256, 0);
    keysLeft = 300;
    for (int i = 0; i < 1000; i++) begin
      r = $urandom_range(0, 1000);
      b = $urandom_range(0, 1000);
      mx = (r > b) ? r : b;
      if (keysLeft > 0 && $urandom_range(0, 999 - i) < keysLeft) begin
        keysLeft--;
        drive(1, r, mx + 257 + $urandom_range(0, 500), b, $urandom_range(0, 4095),
              $urandom_range(0, 4095), $urandom_range(0, 4095), 0);
      end else begin
        drive(1, r, $urandom_range(0, mx + 256), b, 1, 1, 1, 0);
      end
    end
    idle(3);
    frameStart(256, 0);
    check("frame300", {8'b0, oKey_Count}, 300);
    for (int i = 0; i < 200; i++) drive(1, 800, $urandom_range(0, 1056), 300, 1, 1, 1, 0);
    idle(3);
    frameStart(256, 0);
    check("frame0", {8'b0, oKey_Count}, 0);

    // Bypass requested mid-frame takes effect only at the next frame start.
    for (int i = 0; i < 30; i++) begin
      if (i == 10) curByp = 1;
      randPixel();
    end
    idle(3);
    frameStart(256, 1);
    for (int i = 0; i < 60; i++) drive(1, 0, 4000, 0, 1, 1, 1, 0);
    idle(3);
    frameStart(200, 0);
    check("bypass_count", {8'b0, oKey_Count}, 0);

    // Random frames with varying thresholds.
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < 150; i++) begin
        if ($urandom_range(0, 3) == 0) idle(1);
        else randPixel();
      end
      idle(3 + $urandom_range(0, 3));
      frameStart($urandom_range(0, 1500), ($urandom_range(0, 4) == 0) ? 1 : 0);
    end

    // Reset in the middle of a valid burst, then resume.
    frameStart(300, 0);
    for (int i = 0; i < 40; i++) randPixel();
    applyReset();
    for (int i = 0; i < 40; i++) randPixel();
    idle(3);
    frameStart(256, 0);
    for (int i = 0; i < 40; i++) randPixel();
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
